// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit single-cycle datapath: widths, opcode
// field values and the branch-condition encoding.
package cpu_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;

    // Opcode fields, compared against the most significant instruction bits.
    localparam logic [4:0] OP_JMP = 5'b11100;   // instruction[18:14]
    localparam logic [4:0] OP_JSB = 5'b11101;   // instruction[18:14]
    localparam logic [5:0] OP_RET = 6'b111100;  // instruction[18:13]
    localparam logic [2:0] OP_BR  = 3'b101;     // instruction[18:16]

    // Branch condition carried in instruction[15:14].
    typedef enum logic [1:0] {
        BR_Z  = 2'b00,
        BR_NZ = 2'b01,
        BR_C  = 2'b10,
        BR_NC = 2'b11
    } br_cond_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the sequencer, the instruction memory and the
// datapath status/stall signals.
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic               z_flag;
    logic               c_flag;
    logic               stall;
    logic [ADDR_W-1:0]  address;
    logic               stack_overflow;
    logic               stack_underflow;

    // Sequencer side: drives the fetch address and error flags.
    modport master (
        input  instruction,
        input  z_flag,
        input  c_flag,
        input  stall,
        output address,
        output stack_overflow,
        output stack_underflow
    );

    // Memory/datapath side: returns the instruction, flags and stall.
    modport slave (
        output instruction,
        output z_flag,
        output c_flag,
        output stall,
        input  address,
        input  stack_overflow,
        input  stack_underflow
    );

endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack. count_reg holds the number of valid entries;
// the top entry is read combinationally so a RET resolves in its own cycle.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] ONE       = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == DEPTH_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_idx  = count_reg[PTR_W-1:0];
    assign rd_idx  = PTR_W'(count_reg - ONE);
    assign top     = mem[rd_idx];

    // Pointer update; a push into a full stack and a pop from an empty one
    // both leave the pointer alone.
    always_comb begin
        count_next = count_reg;
        if (do_push) begin
            count_next = count_reg + ONE;
        end else if (do_pop) begin
            count_next = count_reg - ONE;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Entry storage; contents are don't-care after reset since count_reg
    // already marks them invalid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and control-flow sequencer: decodes the fetched instruction,
// selects the next PC and manages calls/returns through return_stack.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 12'd0,
    parameter int                STACK_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    pc_sequencer_if.master bus
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus_one;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] stack_top;
    logic [7:0]        offset;
    logic              overflow_reg;
    logic              overflow_next;
    logic              underflow_reg;
    logic              underflow_next;
    logic              is_jmp;
    logic              is_jsb;
    logic              is_ret;
    logic              is_br;
    logic              br_taken;
    logic              push;
    logic              pop;
    logic              stack_full;
    logic              stack_empty;
    logic              unused_ok;

    // Field extraction; bit 12 carries no meaning in any format.
    assign is_jmp      = (bus.instruction[18:14] == OP_JMP);
    assign is_jsb      = (bus.instruction[18:14] == OP_JSB);
    assign is_ret      = (bus.instruction[18:13] == OP_RET);
    assign is_br       = (bus.instruction[18:16] == OP_BR);
    assign target      = bus.instruction[ADDR_W-1:0];
    assign offset      = bus.instruction[7:0];
    assign unused_ok   = bus.instruction[12];
    assign pc_plus_one = pc_reg + ADDR_W'(1);
    assign br_target   = pc_plus_one + {{(ADDR_W-8){offset[7]}}, offset};

    // Branch condition evaluated on the flags presented this cycle.
    always_comb begin
        br_taken = 1'b0;
        case (br_cond_e'(bus.instruction[15:14]))
            BR_Z:    br_taken = bus.z_flag;
            BR_NZ:   br_taken = !bus.z_flag;
            BR_C:    br_taken = bus.c_flag;
            BR_NC:   br_taken = !bus.c_flag;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-PC mux, stack requests and error flag updates. A stall suppresses
    // the stack requests; the registers below ignore the rest.
    always_comb begin
        pc_next        = pc_plus_one;
        push           = 1'b0;
        pop            = 1'b0;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (is_jmp) begin
            pc_next = target;
        end else if (is_jsb) begin
            pc_next = target;
            if (stack_full) begin
                overflow_next = 1'b1;
            end else begin
                push = 1'b1;
            end
        end else if (is_ret) begin
            if (stack_empty) begin
                underflow_next = 1'b1;
            end else begin
                pc_next = stack_top;
                pop     = 1'b1;
            end
        end else if (is_br && br_taken) begin
            pc_next = br_target;
        end
        if (bus.stall) begin
            push = 1'b0;
            pop  = 1'b0;
        end
    end

    // PC and sticky error flags; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (!bus.stall) begin
            pc_reg        <= pc_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus_one),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign bus.address         = pc_reg;
    assign bus.stack_overflow  = overflow_reg;
    assign bus.stack_underflow = underflow_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed control-flow scenarios followed by
// random instruction streams, each cycle compared against a queue-based model.
module tb_pc_sequencer;

    localparam logic [11:0] RESET_PC    = 12'd0;
    localparam int          STACK_DEPTH = 8;

    logic clk;
    logic rst;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC    (RESET_PC),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [11:0] m_pc;
    logic [11:0] m_stack[$];
    logic        m_ovf;
    logic        m_unf;

    function automatic logic [18:0] i_jmp(input logic [11:0] t);
        return {5'b11100, 2'b00, t};
    endfunction

    function automatic logic [18:0] i_jsb(input logic [11:0] t);
        return {5'b11101, 2'b00, t};
    endfunction

    function automatic logic [18:0] i_ret();
        return {6'b111100, 13'd0};
    endfunction

    function automatic logic [18:0] i_br(input logic [1:0] cond, input logic [7:0] off);
        return {3'b101, cond, 6'd0, off};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Apply one cycle of inputs, advance the model by the architectural rules,
    // then compare every observable after the edge.
    task automatic step(input logic [18:0] ins, input logic z, input logic c,
                        input logic st, input logic r);
        logic [11:0] nxt;
        logic        take;
        int          v;
        bus.instruction = ins;
        bus.z_flag      = z;
        bus.c_flag      = c;
        bus.stall       = st;
        rst             = r;
        if (r) begin
            m_pc = RESET_PC;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!st) begin
            nxt = 12'(m_pc + 1);
            if (ins[18:14] == 5'b11100) begin
                nxt = ins[11:0];
            end else if (ins[18:14] == 5'b11101) begin
                if (m_stack.size() < STACK_DEPTH) m_stack.push_back(12'(m_pc + 1));
                else m_ovf = 1'b1;
                nxt = ins[11:0];
            end else if (ins[18:13] == 6'b111100) begin
                if (m_stack.size() == 0) m_unf = 1'b1;
                else nxt = m_stack.pop_back();
            end else if (ins[18:16] == 3'b101) begin
                case (ins[15:14])
                    2'b00:   take = z;
                    2'b01:   take = !z;
                    2'b10:   take = c;
                    default: take = !c;
                endcase
                if (take) begin
                    v   = int'(m_pc) + 1 + int'($signed(ins[7:0]));
                    nxt = 12'(v);
                end
            end
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        check("address", 32'(bus.address), 32'(m_pc));
        check("sp", 32'(dut.u_stack.count_reg), 32'(m_stack.size()));
        check("overflow", 32'(bus.stack_overflow), 32'(m_ovf));
        check("underflow", 32'(bus.stack_underflow), 32'(m_unf));
        $display("step ins=%05h z=%0b c=%0b stall=%0b rst=%0b -> address=%0d sp=%0d ovf=%0b unf=%0b",
                 ins, z, c, st, r, bus.address, dut.u_stack.count_reg,
                 bus.stack_overflow, bus.stack_underflow);
    endtask

    function automatic logic [18:0] rand_instr();
        logic [18:0] ins;
        case ($urandom_range(0, 6))
            0:       ins = i_jmp(12'($urandom));
            1:       ins = i_jsb(12'($urandom));
            2, 3:    ins = i_ret();
            4:       ins = i_br(2'($urandom), 8'($urandom));
            5:       ins = 19'($urandom);
            default: ins = 19'd0;
        endcase
        return ins;
    endfunction

    initial begin
        bus.instruction = '0;
        bus.z_flag      = 1'b0;
        bus.c_flag      = 1'b0;
        bus.stall       = 1'b0;
        rst             = 1'b1;
        m_pc            = RESET_PC;
        m_ovf           = 1'b0;
        m_unf           = 1'b0;

        // Reset, then sequential fetch from zero instructions
        step(19'd0, 0, 0, 0, 1);
        check("reset_addr", 32'(bus.address), 32'd0);
        for (int i = 0; i < 4; i++) step(19'd0, 0, 0, 0, 0);
        check("seq_addr4", 32'(bus.address), 32'd4);
        step(19'd0, 0, 0, 1, 1);
        step(i_jmp(12'd7), 0, 0, 1, 1);
        check("rst_over_stall", 32'(bus.address), 32'd0);

        // JMP / JSB / RET
        step(i_jmp(12'd14), 0, 0, 0, 0);
        step(i_jmp(12'd20), 0, 0, 0, 0);
        check("jmp20", 32'(bus.address), 32'd20);
        step(19'd0, 0, 0, 0, 0);
        step(i_jsb(12'd32), 0, 0, 0, 0);
        check("jsb32", 32'(bus.address), 32'd32);
        step(i_ret(), 0, 0, 0, 0);
        check("ret22", 32'(bus.address), 32'd22);

        // Conditional branches including wrap-around
        step(i_jmp(12'd3), 0, 0, 0, 0);
        step(i_br(2'b00, 8'd13), 1, 0, 0, 0);
        check("brz_taken", 32'(bus.address), 32'd17);
        step(i_jmp(12'd3), 0, 0, 0, 0);
        step(i_br(2'b00, 8'd13), 0, 0, 0, 0);
        check("brz_not", 32'(bus.address), 32'd4);
        step(19'd0, 0, 0, 0, 0);
        step(i_br(2'b11, 8'hFE), 0, 0, 0, 0);
        check("brnc_back", 32'(bus.address), 32'd4);
        step(i_jmp(12'd4095), 0, 0, 0, 0);
        step(i_br(2'b10, 8'd9), 0, 0, 0, 0);
        check("brc_wrap", 32'(bus.address), 32'd0);
        step(i_br(2'b01, 8'hF0), 1, 1, 0, 0);
        step(i_jmp(12'd2), 0, 0, 0, 0);
        step(i_br(2'b01, 8'hF0), 0, 1, 0, 0);
        check("brnz_negwrap", 32'(bus.address), 32'd4083);

        // Nine nested calls, eight returns, then underflow
        step(19'd0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(19'd0, 0, 0, 0, 0);
            step(i_jsb(12'(100 + 10 * i)), 0, 0, 0, 0);
        end
        check("ovf_set", 32'(bus.stack_overflow), 32'd1);
        check("ninth_jump", 32'(bus.address), 32'd180);
        for (int i = 0; i < 8; i++) step(i_ret(), 0, 0, 0, 0);
        check("last_ret", 32'(bus.address), 32'd2);
        step(i_ret(), 0, 0, 0, 0);
        check("unf_set", 32'(bus.stack_underflow), 32'd1);
        check("unf_seq", 32'(bus.address), 32'd3);
        step(19'd0, 0, 0, 0, 0);
        step(i_jmp(12'd50), 0, 0, 0, 0);
        check("ovf_sticky", 32'(bus.stack_overflow), 32'd1);
        step(19'd0, 0, 0, 0, 1);

        // Stall holds a pending JSB for three cycles
        for (int i = 0; i < 3; i++) step(i_jsb(12'd300), 0, 0, 1, 0);
        check("stall_hold", 32'(bus.address), 32'd0);
        step(i_jsb(12'd300), 0, 0, 0, 0);
        check("stall_release", 32'(bus.address), 32'd300);
        check("one_push", 32'(dut.u_stack.count_reg), 32'd1);

        // Reset mid call chain drops all return addresses
        step(i_jsb(12'd400), 0, 0, 0, 0);
        step(i_jsb(12'd500), 0, 0, 0, 0);
        step(19'd0, 0, 0, 0, 1);
        check("rst_sp", 32'(dut.u_stack.count_reg), 32'd0);
        step(i_ret(), 0, 0, 0, 0);
        check("ret_after_rst", 32'(bus.stack_underflow), 32'd1);

        // Random instruction streams with stalls and occasional resets
        step(19'd0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
